load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the CPU's data-memory interface. Accepts one load or store at a time from the execute/memory stage over a valid/ready handshake and drives the data memory's 64-bit port. The memory reads and writes whole little-endian doublewords; this block sign- or zero-extends byte/half/word/double loads and read-modify-writes narrower stores. It returns each result with a single-cycle response pulse.

## Interface
- MEM_BYTES, 64: data memory size in bytes; every byte address is taken modulo MEM_BYTES.
- MISALIGN_CHECK, 1: 1 = reject accesses whose address is not a multiple of the access size; 0 = allow them.
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data in the low 8/16/32/64 bits.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  64  extended load data; 0 for stores.
- rsp_misaligned  out  1  access rejected; valid with rsp_valid.
- Mem_Addr  out  64  doubleword byte address to memory.
- MemRead  out  1  read strobe.
- MemWrite  out  1  write strobe; the memory writes 8 bytes on the clk edge while high.
- Write_Data  out  64  doubleword to write.
- Read_Data  in  64  combinational memory read data for Mem_Addr.

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- req_ready = 1 only in IDLE. A request is accepted on an edge where req_valid and req_ready are both high. At acceptance, addr, size, store, unsigned and wdata are latched.
- Misaligned check: when MISALIGN_CHECK = 1 and addr mod 2^size is not 0, the block goes IDLE→RESP with rsp_misaligned = 1. No MemRead or MemWrite is issued.
- Load: IDLE→LOAD→RESP.
  - In LOAD: MemRead = 1 and Mem_Addr = latched address.
  - At the end of LOAD, Read_Data is captured. The low 1/2/4/8 bytes are kept and extended per req_unsigned. Size 11 ignores req_unsigned.
- Store, size 11: IDLE→WRITE→RESP. In WRITE, Write_Data = wdata and MemWrite = 1.
- Store, size < 11: IDLE→RMW_READ→WRITE→RESP.
  - In RMW_READ: MemRead = 1 and Read_Data is captured.
  - Merged word = captured data with its low N bytes replaced by the low N bytes of wdata.
  - In WRITE: the merged word is written with MemWrite = 1.
- RESP: rsp_valid = 1 for exactly one cycle, then → IDLE.
- Mem_Addr is held at the latched address from acceptance until the return to IDLE. It is 0 in IDLE.
- Address wrap-around (e.g. a doubleword at MEM_BYTES−4) is handled entirely by the memory; this block passes addresses unmodified.

## Timing
- All outputs are registered.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_misaligned 0, Mem_Addr 0, MemRead 0, MemWrite 0, Write_Data 0.
- Latency, counting the acceptance edge as cycle 0:
  - Load: rsp_valid in cycle 2.
  - Doubleword store: MemWrite in cycle 1, rsp_valid in cycle 2.
  - Narrow store: MemRead in cycle 1, MemWrite in cycle 2, rsp_valid in cycle 3.
  - Misaligned: rsp_valid in cycle 1.
- MemWrite is high for exactly one cycle per store. MemRead and MemWrite are never high together.
- A new request can be accepted on the edge that ends RESP+1, i.e. once the block is back in IDLE. Requests are not accepted back-to-back with RESP.
- Reset asserted mid-operation forces all outputs to their reset values immediately (MemWrite drops asynchronously). The in-flight access is dropped with no response.
- req_* inputs are ignored outside the acceptance edge.

## Structure
- Package lsu_pkg holds:
  - size encodings: SZ_B, SZ_H, SZ_W, SZ_D;
  - the state enum;
  - byte-count and alignment-mask functions of size.
- One sub-module, lsu_data_align, is combinational and has two functions:
  - extends the low bytes of a doubleword by size and unsigned;
  - merges store bytes into a doubleword by size.
- It is instantiated once for the load path and once for the merge path.

## Test plan
The bench uses a behavioral memory with byte i = i+1 for i 0–44, 0 for 45–51, and i+1 for 52–63.
- ld addr 0 → rsp_rdata 0x0807060504030201, rsp_valid in cycle 2, one MemRead cycle, no MemWrite.
- sb 0x80 @8, then lb @8 → 0xFFFFFFFFFFFFFF80; lbu @8 → 0x80. Memory byte 9 stays 0x0A.
- sh 0xBEEF @16 → MemRead cycle 1, MemWrite cycle 2 with Write_Data 0x181716151413BEEF, rsp_valid cycle 3.
- lw @2 with MISALIGN_CHECK=1 → rsp_misaligned 1 in cycle 1, MemRead and MemWrite never asserted. With MISALIGN_CHECK=0, ld @60 → 0x04030201403F3E3D.
- sd 0x1122334455667788 @24, then ld @24 → 0x1122334455667788. req_valid held high during busy cycles is accepted only in IDLE.
- reset_n low during WRITE of sd @32 → MemWrite falls immediately, no rsp_valid, memory @32 unchanged. req_ready is 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and size helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    WRITE,
    RESP
  } state_e;

  function automatic logic [3:0] size_bytes(input size_e sz);
    return 4'd1 << sz;
  endfunction

  function automatic logic [2:0] align_mask(input size_e sz);
    return 3'(size_bytes(sz) - 4'd1);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channel from the pipeline and the 64-bit data-memory port.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_misaligned;

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned
  );
  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned
  );
endinterface

interface lsu_mem_if;
  logic [63:0] Mem_Addr;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] Write_Data;
  logic [63:0] Read_Data;

  modport master (
    output Mem_Addr, MemRead, MemWrite, Write_Data,
    input  Read_Data
  );
  modport slave (
    input  Mem_Addr, MemRead, MemWrite, Write_Data,
    output Read_Data
  );
endinterface

// File: rtl/lsu_data_align.sv
// Combinational byte lane handling: load extension (merge=0) or store byte merge (merge=1).
module lsu_data_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic        merge,
  input  logic [63:0] base,
  input  logic [63:0] wdata,
  output logic [63:0] data_out
);

  logic [6:0]  nbits;
  logic [63:0] keep;
  logic        sign;

  always_comb begin
    nbits = {size_bytes(size), 3'b000};
    keep  = (size == SZ_D) ? '1 : ((64'd1 << nbits) - 64'd1);
    sign  = base[6'(nbits - 7'd1)];
    if (merge) begin
      data_out = (base & ~keep) | (wdata & keep);
    end else begin
      data_out = (base & keep) | ((sign && !is_unsigned) ? ~keep : '0);
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, narrow stores done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES      = 64,
  parameter bit          MISALIGN_CHECK = 1'b1
) (
  input  logic      clk,
  input  logic      reset_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  // Wrap-around is the memory's job; the size is only sanity-checked here.
  if (MEM_BYTES < 8 || (MEM_BYTES % 8) != 0) begin : g_bad_mem_bytes
    $error("load_store_unit: MEM_BYTES must be a non-zero multiple of 8");
  end

  state_e      state;
  size_e       size_q;
  logic        unsigned_q;
  logic [63:0] wdata_q;
  logic [63:0] load_data;
  logic [63:0] merge_data;
  size_e       req_sz;
  logic        misaligned;

  assign req_sz     = size_e'(req.req_size);
  assign misaligned = MISALIGN_CHECK && ((req.req_addr[2:0] & align_mask(req_sz)) != 3'b000);

  lsu_data_align u_load_align (
    .size       (size_q),
    .is_unsigned(unsigned_q),
    .merge      (1'b0),
    .base       (mem.Read_Data),
    .wdata      ('0),
    .data_out   (load_data)
  );

  lsu_data_align u_merge_align (
    .size       (size_q),
    .is_unsigned(1'b0),
    .merge      (1'b1),
    .base       (mem.Read_Data),
    .wdata      (wdata_q),
    .data_out   (merge_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      size_q             <= SZ_B;
      unsigned_q         <= 1'b0;
      wdata_q            <= '0;
      req.req_ready      <= 1'b1;
      req.rsp_valid      <= 1'b0;
      req.rsp_rdata      <= '0;
      req.rsp_misaligned <= 1'b0;
      mem.Mem_Addr       <= '0;
      mem.MemRead        <= 1'b0;
      mem.MemWrite       <= 1'b0;
      mem.Write_Data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req.req_valid) begin
            size_q        <= req_sz;
            unsigned_q    <= req.req_unsigned;
            wdata_q       <= req.req_wdata;
            mem.Mem_Addr  <= req.req_addr;
            req.req_ready <= 1'b0;
            req.rsp_rdata <= '0;
            if (misaligned) begin
              state              <= RESP;
              req.rsp_valid      <= 1'b1;
              req.rsp_misaligned <= 1'b1;
            end else if (!req.req_store) begin
              state       <= LOAD;
              mem.MemRead <= 1'b1;
            end else if (req_sz == SZ_D) begin
              state          <= WRITE;
              mem.MemWrite   <= 1'b1;
              mem.Write_Data <= req.req_wdata;
            end else begin
              state       <= RMW_READ;
              mem.MemRead <= 1'b1;
            end
          end
        end
        LOAD: begin
          state         <= RESP;
          mem.MemRead   <= 1'b0;
          req.rsp_valid <= 1'b1;
          req.rsp_rdata <= load_data;
        end
        RMW_READ: begin
          state          <= WRITE;
          mem.MemRead    <= 1'b0;
          mem.MemWrite   <= 1'b1;
          mem.Write_Data <= merge_data;
        end
        WRITE: begin
          state          <= RESP;
          mem.MemWrite   <= 1'b0;
          mem.Write_Data <= '0;
          req.rsp_valid  <= 1'b1;
        end
        RESP: begin
          state              <= IDLE;
          req.rsp_valid      <= 1'b0;
          req.rsp_misaligned <= 1'b0;
          mem.Mem_Addr       <= '0;
          req.req_ready      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: two LSUs (alignment check on/off) sharing one behavioral byte memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct {
    int          lat;
    logic [63:0] rdata;
    logic        mis;
    int          rd_cnt;
    int          rd_cyc;
    int          wr_cnt;
    int          wr_cyc;
    logic [63:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   overlap = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  lsu_req_if q0 ();
  lsu_req_if q1 ();
  lsu_mem_if m0 ();
  lsu_mem_if m1 ();

  load_store_unit #(.MEM_BYTES(64), .MISALIGN_CHECK(1'b1)) dut_chk (
    .clk(clk), .reset_n(reset_n), .req(q0.slave), .mem(m0.master)
  );
  load_store_unit #(.MEM_BYTES(64), .MISALIGN_CHECK(1'b0)) dut_nochk (
    .clk(clk), .reset_n(reset_n), .req(q1.slave), .mem(m1.master)
  );

  logic        v_valid [2];
  logic        v_store [2];
  logic        v_uns   [2];
  logic [1:0]  v_size  [2];
  logic [63:0] v_addr  [2];
  logic [63:0] v_wdata [2];

  assign q0.req_valid = v_valid[0];  assign q1.req_valid = v_valid[1];
  assign q0.req_store = v_store[0];  assign q1.req_store = v_store[1];
  assign q0.req_unsigned = v_uns[0]; assign q1.req_unsigned = v_uns[1];
  assign q0.req_size = v_size[0];    assign q1.req_size = v_size[1];
  assign q0.req_addr = v_addr[0];    assign q1.req_addr = v_addr[1];
  assign q0.req_wdata = v_wdata[0];  assign q1.req_wdata = v_wdata[1];

  logic        t_ready [2];
  logic        t_rsp   [2];
  logic        t_mis   [2];
  logic [63:0] t_rdata [2];
  logic        t_rd    [2];
  logic        t_wr    [2];
  logic [63:0] t_wdat  [2];

  assign t_ready[0] = q0.req_ready;      assign t_ready[1] = q1.req_ready;
  assign t_rsp[0]   = q0.rsp_valid;      assign t_rsp[1]   = q1.rsp_valid;
  assign t_mis[0]   = q0.rsp_misaligned; assign t_mis[1]   = q1.rsp_misaligned;
  assign t_rdata[0] = q0.rsp_rdata;      assign t_rdata[1] = q1.rsp_rdata;
  assign t_rd[0]    = m0.MemRead;        assign t_rd[1]    = m1.MemRead;
  assign t_wr[0]    = m0.MemWrite;       assign t_wr[1]    = m1.MemWrite;
  assign t_wdat[0]  = m0.Write_Data;     assign t_wdat[1]  = m1.Write_Data;

  logic [7:0] mem [64];

  always_comb begin
    m0.Read_Data = '0;
    m1.Read_Data = '0;
    for (int k = 0; k < 8; k++) begin
      m0.Read_Data[8*k +: 8] = mem[6'(m0.Mem_Addr[5:0] + 6'(k))];
      m1.Read_Data[8*k +: 8] = mem[6'(m1.Mem_Addr[5:0] + 6'(k))];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (m0.MemWrite) mem[6'(m0.Mem_Addr[5:0] + 6'(k))] <= m0.Write_Data[8*k +: 8];
      if (m1.MemWrite) mem[6'(m1.Mem_Addr[5:0] + 6'(k))] <= m1.Write_Data[8*k +: 8];
    end
  end

  function automatic logic [63:0] mem64(input logic [5:0] a);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = mem[6'(a + 6'(k))];
    return r;
  endfunction

  // Per-DUT transaction monitor; cycle 1 is the period right after the acceptance edge.
  int          acc    [2];
  int          rd_cnt [2];
  int          rd_cyc [2];
  int          wr_cnt [2];
  int          wr_cyc [2];
  logic [63:0] wd_seen[2];

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      for (int d = 0; d < 2; d++) begin
        if (t_rd[d] && t_wr[d]) overlap++;
        if (t_rd[d]) begin
          if (rd_cnt[d] == 0) rd_cyc[d] = cyc - acc[d];
          rd_cnt[d]++;
        end
        if (t_wr[d]) begin
          if (wr_cnt[d] == 0) wr_cyc[d] = cyc - acc[d];
          wr_cnt[d]++;
          wd_seen[d] = t_wdat[d];
        end
        if (t_rsp[d]) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_rsp", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check_eq("latency", 64'(cyc - acc[d]), 64'(e.lat));
            check_eq("rdata", t_rdata[d], e.rdata);
            check_eq("misaligned", 64'(t_mis[d]), 64'(e.mis));
            check_eq("memread_cycles", 64'(rd_cnt[d]), 64'(e.rd_cnt));
            check_eq("memread_first", 64'(rd_cyc[d]), 64'(e.rd_cyc));
            check_eq("memwrite_cycles", 64'(wr_cnt[d]), 64'(e.wr_cnt));
            check_eq("memwrite_first", 64'(wr_cyc[d]), 64'(e.wr_cyc));
            if (e.wr_cnt > 0) check_eq("write_data", wd_seen[d], e.wdata);
          end
        end
        if (v_valid[d] && t_ready[d]) begin
          acc[d]    = cyc;
          rd_cnt[d] = 0;
          wr_cnt[d] = 0;
          rd_cyc[d] = -1;
          wr_cyc[d] = -1;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the acceptance edge with req_valid still high.
  task automatic do_req(input int d, input logic st, input size_e sz, input logic un,
                        input logic [63:0] a, input logic [63:0] wd,
                        input exp_t e, input bit push, output int acc_at);
    int n;
    v_store[d] = st;
    v_size[d]  = sz;
    v_uns[d]   = un;
    v_addr[d]  = a;
    v_wdata[d] = wd;
    v_valid[d] = 1'b1;
    if (push) sb.push_back(e);
    n = 0;
    @(negedge clk);
    while (!t_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!t_ready[d]) check_eq("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    acc_at = cyc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("rsp_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int lat, input logic [63:0] rdata, input logic mis,
                              input int rdn, input int rdc, input int wrn, input int wrc,
                              input logic [63:0] wdata);
    exp_t e;
    e.lat = lat; e.rdata = rdata; e.mis = mis;
    e.rd_cnt = rdn; e.rd_cyc = rdc; e.wr_cnt = wrn; e.wr_cyc = wrc; e.wdata = wdata;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    for (int i = 0; i < 64; i++) mem[i] <= (i < 45 || i >= 52) ? 8'(i + 1) : 8'h00;
    for (int d = 0; d < 2; d++) begin
      v_valid[d] = 1'b0; v_store[d] = 1'b0; v_uns[d] = 1'b0;
      v_size[d] = 2'b00; v_addr[d] = '0; v_wdata[d] = '0;
      acc[d] = 0; rd_cnt[d] = 0; rd_cyc[d] = -1; wr_cnt[d] = 0; wr_cyc[d] = -1; wd_seen[d] = '0;
    end

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 64'(q0.req_ready), 64'd1);
    check_eq("rst_rsp_valid", 64'(q0.rsp_valid), 64'd0);
    check_eq("rst_rsp_rdata", q0.rsp_rdata, 64'd0);
    check_eq("rst_mem_addr", m0.Mem_Addr, 64'd0);
    check_eq("rst_mem_strobes", 64'({m0.MemRead, m0.MemWrite}), 64'd0);
    check_eq("rst_write_data", m0.Write_Data, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    do_req(0, 1'b0, SZ_D, 1'b0, 64'd0, '0, mk(2, 64'h0807060504030201, 1'b0, 1, 1, 0, -1, '0), 1'b1, a0);
    v_valid[0] = 1'b0; drain();

    do_req(0, 1'b1, SZ_B, 1'b0, 64'd8, 64'h80, mk(3, '0, 1'b0, 1, 1, 1, 2, 64'h100F0E0D0C0B0A80), 1'b1, a0);
    v_valid[0] = 1'b0; drain();
    do_req(0, 1'b0, SZ_B, 1'b0, 64'd8, '0, mk(2, 64'hFFFFFFFFFFFFFF80, 1'b0, 1, 1, 0, -1, '0), 1'b1, a0);
    v_valid[0] = 1'b0; drain();
    do_req(0, 1'b0, SZ_B, 1'b1, 64'd8, '0, mk(2, 64'h0000000000000080, 1'b0, 1, 1, 0, -1, '0), 1'b1, a0);
    v_valid[0] = 1'b0; drain();
    check_eq("sb_byte9_kept", 64'(mem[9]), 64'h0A);

    do_req(0, 1'b1, SZ_H, 1'b0, 64'd16, 64'hDEAD00000000BEEF, mk(3, '0, 1'b0, 1, 1, 1, 2, 64'h181716151413BEEF), 1'b1, a0);
    v_valid[0] = 1'b0; drain();
    do_req(0, 1'b0, SZ_H, 1'b0, 64'd16, '0, mk(2, 64'hFFFFFFFFFFFFBEEF, 1'b0, 1, 1, 0, -1, '0), 1'b1, a0);
    v_valid[0] = 1'b0; drain();
    do_req(0, 1'b0, SZ_W, 1'b1, 64'd16, '0, mk(2, 64'h000000001413BEEF, 1'b0, 1, 1, 0, -1, '0), 1'b1, a0);
    v_valid[0] = 1'b0; drain();

    do_req(0, 1'b0, SZ_W, 1'b0, 64'd2, '0, mk(1, '0, 1'b1, 0, -1, 0, -1, '0), 1'b1, a0);
    v_valid[0] = 1'b0; drain();
    do_req(0, 1'b1, SZ_H, 1'b0, 64'd5, 64'hFFFF, mk(1, '0, 1'b1, 0, -1, 0, -1, '0), 1'b1, a0);
    v_valid[0] = 1'b0; drain();
    check_eq("mis_store_mem", mem64(6'd0), 64'h0807060504030201);

    do_req(1, 1'b0, SZ_W, 1'b1, 64'd2, '0, mk(2, 64'h0000000006050403, 1'b0, 1, 1, 0, -1, '0), 1'b1, a0);
    v_valid[1] = 1'b0; drain();
    do_req(1, 1'b0, SZ_D, 1'b0, 64'd60, '0, mk(2, 64'h04030201403F3E3D, 1'b0, 1, 1, 0, -1, '0), 1'b1, a0);
    v_valid[1] = 1'b0; drain();

    // req_valid stays high across the store so the load is offered during busy cycles.
    do_req(0, 1'b1, SZ_D, 1'b0, 64'd24, 64'h1122334455667788, mk(2, '0, 1'b0, 0, -1, 1, 1, 64'h1122334455667788), 1'b1, a0);
    do_req(0, 1'b0, SZ_D, 1'b1, 64'd24, '0, mk(2, 64'h1122334455667788, 1'b0, 1, 1, 0, -1, '0), 1'b1, a1);
    v_valid[0] = 1'b0;
    check_eq("busy_accept_gap", 64'(a1 - a0), 64'd3);
    drain();

    do_req(0, 1'b1, SZ_D, 1'b0, 64'd32, 64'hCAFEF00DCAFEF00D, mk(0, '0, 1'b0, 0, -1, 0, -1, '0), 1'b0, a0);
    v_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("sd_write_active", 64'(m0.MemWrite), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("rst_async_memwrite", 64'(m0.MemWrite), 64'd0);
    check_eq("rst_async_ready", 64'(q0.req_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rst_mem32_kept", mem64(6'd32), 64'h2827262524232221);
    check_eq("rst_ready_after", 64'(q0.req_ready), 64'd1);
    check_eq("rst_no_rsp", 64'(q0.rsp_valid), 64'd0);

    drain();
    check_eq("rd_wr_overlap", 64'(overlap), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
